// File: rtl/alarm_pkg.sv
// ============================================================================
// Module  : alarm_pkg
// Brief   : Shared state encoding, field widths and constants for alarm_ctrl.
// Revision: 1.0
// ============================================================================
`default_nettype none

package alarm_pkg;

    localparam int HOUR_W  = 5;
    localparam int MIN_W   = 6;
    localparam int SEC_W   = 6;
    localparam int STATE_W = 3;

    localparam int HOUR_MOD = 24;
    localparam int MIN_MOD  = 60;

    localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;
    localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;

    localparam logic [HOUR_W-1:0] RST_AL_HOUR = 5'd6;
    localparam logic [MIN_W-1:0]  RST_AL_MIN  = 6'd0;

    typedef enum logic [STATE_W-1:0] {
        ST_RUN      = 3'd0,
        ST_SET_HR   = 3'd1,
        ST_SET_MIN  = 3'd2,
        ST_SET_AHR  = 3'd3,
        ST_SET_AMIN = 3'd4,
        ST_RING     = 3'd5,
        ST_SNOOZE   = 3'd6
    } state_t;

    function automatic logic [HOUR_W-1:0] hour_inc(input logic [HOUR_W-1:0] v);
        return (v == HOUR_MAX) ? '0 : v + 1'b1;
    endfunction

    function automatic logic [MIN_W-1:0] min_inc(input logic [MIN_W-1:0] v);
        return (v == MIN_MAX) ? '0 : v + 1'b1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mod_counter.sv
// ============================================================================
// Module  : mod_counter
// Brief   : Modulo-N counter with enable, synchronous clear and carry-out.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mod_counter #(
    parameter int MOD = 60,
    parameter int W   = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         carry
);

    localparam logic [W-1:0] c_max = W'(MOD - 1);

    // Carry is only meaningful on the cycle the counter actually wraps.
    assign carry = en & ~clr & (count == c_max);

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= carry ? '0 : count + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/alarm_ctrl.sv
// ============================================================================
// Module  : alarm_ctrl
// Brief   : Alarm clock controller: timekeeping, set modes, ring and snooze.
//           Optional snooze support is enabled by `define ALARM_CTRL_SNOOZE_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module alarm_ctrl
    import alarm_pkg::*;
#(
    parameter int SNOOZE_MIN = 5,
    parameter int RING_SEC   = 60
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick_in,
    input  logic              mode_btn,
    input  logic              inc_btn,
    input  logic              alarm_off,
    output logic              div_en,
    output logic [HOUR_W-1:0] hour,
    output logic [MIN_W-1:0]  min,
    output logic [SEC_W-1:0]  sec,
    output logic [HOUR_W-1:0] al_hour,
    output logic [MIN_W-1:0]  al_min,
    output logic [STATE_W-1:0] state,
    output logic              buzzer
);

    if (SNOOZE_MIN < 1 || SNOOZE_MIN > 59) begin : g_bad_snooze_min
        $error("SNOOZE_MIN out of range 1..59");
    end
    if (RING_SEC < 1 || RING_SEC > 255) begin : g_bad_ring_sec
        $error("RING_SEC out of range 1..255");
    end

    localparam logic [7:0] c_ring_load = 8'(RING_SEC);

    state_t      r_state;
    logic [7:0]  r_ring_cnt;

    logic w_inc;
    logic w_set_time;
    logic w_sec_en;
    logic w_min_en;
    logic w_hour_en;
    logic w_sec_co;
    logic w_min_co;
    logic w_hour_co;
    logic w_match;
    logic [MIN_W-1:0]  w_min_nxt;
    logic [HOUR_W-1:0] w_hour_nxt;

    // A simultaneous mode press swallows the increment.
    assign w_inc      = inc_btn & ~mode_btn;
    assign w_set_time = (r_state == ST_SET_HR) || (r_state == ST_SET_MIN);
    assign w_sec_en   = tick_in & ~w_set_time;
    assign w_min_en   = w_sec_co | ((r_state == ST_SET_MIN) & w_inc);
    assign w_hour_en  = (w_sec_co & w_min_co) | ((r_state == ST_SET_HR) & w_inc);

    mod_counter #(.MOD(MIN_MOD), .W(SEC_W)) u_sec (
        .clk   (clk),
        .rst   (rst),
        .en    (w_sec_en),
        .clr   (w_set_time),
        .count (sec),
        .carry (w_sec_co)
    );

    mod_counter #(.MOD(MIN_MOD), .W(MIN_W)) u_min (
        .clk   (clk),
        .rst   (rst),
        .en    (w_min_en),
        .clr   (1'b0),
        .count (min),
        .carry (w_min_co)
    );

    mod_counter #(.MOD(HOUR_MOD), .W(HOUR_W)) u_hour (
        .clk   (clk),
        .rst   (rst),
        .en    (w_hour_en),
        .clr   (1'b0),
        .count (hour),
        .carry (w_hour_co)
    );

    // Compare against the time being written this cycle so RING lands with the :00 update.
    assign w_min_nxt  = w_sec_co ? (w_min_co ? '0 : min + 1'b1) : min;
    assign w_hour_nxt = (w_sec_co & w_min_co) ? (w_hour_co ? '0 : hour + 1'b1) : hour;
    assign w_match    = (r_state == ST_RUN) & w_sec_co &
                        (w_hour_nxt == al_hour) & (w_min_nxt == al_min);

    assign state = r_state;

`ifdef ALARM_CTRL_SNOOZE_EN
    localparam logic [11:0] c_snz_load = 12'(SNOOZE_MIN * 60);
    logic [11:0] r_snz_cnt;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= ST_RUN;
            buzzer     <= 1'b0;
            div_en     <= 1'b0;
            al_hour    <= RST_AL_HOUR;
            al_min     <= RST_AL_MIN;
            r_ring_cnt <= '0;
`ifdef ALARM_CTRL_SNOOZE_EN
            r_snz_cnt  <= '0;
`endif
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (mode_btn) begin
                        r_state <= ST_SET_HR;
                        div_en  <= 1'b0;
                    end else begin
                        div_en <= 1'b1;
                        if (w_match) begin
                            r_state    <= ST_RING;
                            buzzer     <= 1'b1;
                            r_ring_cnt <= c_ring_load;
                        end
                    end
                end
                ST_SET_HR: begin
                    if (mode_btn) begin
                        r_state <= ST_SET_MIN;
                    end
                end
                ST_SET_MIN: begin
                    if (mode_btn) begin
                        r_state <= ST_SET_AHR;
                        div_en  <= 1'b1;
                    end
                end
                ST_SET_AHR: begin
                    if (mode_btn) begin
                        r_state <= ST_SET_AMIN;
                    end else if (w_inc) begin
                        al_hour <= hour_inc(al_hour);
                    end
                end
                ST_SET_AMIN: begin
                    if (mode_btn) begin
                        r_state <= ST_RUN;
                    end else if (w_inc) begin
                        al_min <= min_inc(al_min);
                    end
                end
                ST_RING: begin
                    if (alarm_off || mode_btn) begin
                        r_state <= ST_RUN;
                        buzzer  <= 1'b0;
`ifdef ALARM_CTRL_SNOOZE_EN
                    end else if (inc_btn) begin
                        r_state   <= ST_SNOOZE;
                        buzzer    <= 1'b0;
                        r_snz_cnt <= c_snz_load;
`endif
                    end else if (tick_in) begin
                        if (r_ring_cnt <= 8'd1) begin
                            r_state <= ST_RUN;
                            buzzer  <= 1'b0;
                        end else begin
                            r_ring_cnt <= r_ring_cnt - 1'b1;
                        end
                    end
                end
`ifdef ALARM_CTRL_SNOOZE_EN
                ST_SNOOZE: begin
                    if (alarm_off || mode_btn) begin
                        r_state <= ST_RUN;
                    end else if (tick_in) begin
                        if (r_snz_cnt <= 12'd1) begin
                            r_state    <= ST_RING;
                            buzzer     <= 1'b1;
                            r_ring_cnt <= c_ring_load;
                        end else begin
                            r_snz_cnt <= r_snz_cnt - 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    r_state <= ST_RUN;
                    buzzer  <= 1'b0;
                    div_en  <= 1'b1;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/alarm_ctrl.md
ALARM_CTRL -- requirements
Module: alarm_ctrl

Interface
REQ-001 Parameter SNOOZE_MIN, default 5: snooze length in minutes, range 1..59.
REQ-002 Parameter RING_SEC, default 60: ring auto-timeout in seconds, range 1..255.
REQ-003 clk  input  1  system clock.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 tick_in  input  1  one-cycle pulse per second from the clock divider.
REQ-006 mode_btn  input  1  debounced one-cycle pulse: advance mode.
REQ-007 inc_btn  input  1  debounced one-cycle pulse: increment field / snooze.
REQ-008 alarm_off  input  1  one-cycle pulse: stop alarm.
REQ-009 div_en  output  1  divider enable; 0 holds the divider in reset.
REQ-010 hour  output  5  time hours, 0..23.
REQ-011 min  output  6  time minutes, 0..59.
REQ-012 sec  output  6  time seconds, 0..59.
REQ-013 al_hour / al_min  output  5 / 6  alarm time.
REQ-014 state  output  3  current FSM state encoding.
REQ-015 buzzer  output  1  high while ringing.

Function
REQ-016 FSM states SHALL be RUN=0, SET_HR=1, SET_MIN=2, SET_AHR=3, SET_AMIN=4, RING=5, SNOOZE=6.
REQ-017 mode_btn SHALL step RUN->SET_HR->SET_MIN->SET_AHR->SET_AMIN->RUN, one step per pulse, taking effect the next cycle.
REQ-018 In SET_HR / SET_MIN, inc_btn SHALL increment hour (23->0) / min (59->0), sec SHALL be forced to 0, and tick_in SHALL be ignored.
REQ-019 In SET_AHR / SET_AMIN, inc_btn SHALL increment al_hour / al_min with the same wrap, and time SHALL keep advancing.
REQ-020 div_en SHALL be 0 in SET_HR and SET_MIN and 1 in every other state, so timekeeping restarts on a full second.
REQ-021 Each tick_in outside SET_HR/SET_MIN SHALL advance sec; 59->0 carries into min; min 59->0 carries into hour; 23:59:59 wraps to 00:00:00 in one cycle.
REQ-022 In RUN, a tick producing sec==0 with hour==al_hour and min==al_min SHALL enter RING in the same update.
REQ-023 Alarm matches in any state other than RUN SHALL be ignored, with no retrigger.
REQ-024 buzzer SHALL be 1 exactly while state==RING and registered with state.
REQ-025 In RING, alarm_off or mode_btn SHALL return to RUN; RING_SEC ticks without either SHALL also return to RUN.
REQ-026 If mode_btn and inc_btn arrive in the same cycle, mode_btn SHALL win and inc_btn SHALL be dropped.
REQ-027 If tick_in and a button arrive in the same cycle, both SHALL be applied; the FSM transition and the time update SHALL be independent.
REQ-028 inc_btn in RUN SHALL have no effect.

Reset
REQ-029 With rst=0 at a clk edge: state=RUN, hour/min/sec=0, al_hour=6, al_min=0, buzzer=0, div_en=0, internal ring/snooze counters=0.
REQ-030 div_en SHALL become 1 on the first cycle after rst releases; reset mid-RING SHALL clear buzzer the next edge.

Configuration
REQ-031 Macro ALARM_CTRL_SNOOZE_EN: when defined, inc_btn in RING SHALL enter SNOOZE (buzzer 0), and after SNOOZE_MIN*60 ticks the FSM SHALL re-enter RING with the ring timer reloaded; alarm_off or mode_btn in SNOOZE SHALL go to RUN.
REQ-032 Without ALARM_CTRL_SNOOZE_EN: the SNOOZE state and its counter SHALL be absent, and inc_btn in RING SHALL be ignored.

Structure
REQ-033 Package alarm_pkg SHALL hold the state encoding, field widths, the reset alarm time, and the 23/59 wrap constants.
REQ-034 One sub-module, mod_counter (parameterised modulus, enable, load-zero, carry-out), SHALL be instantiated for sec, min, and hour.

Verification
REQ-035 Reset, then 3661 ticks -> hour=1, min=1, sec=1, div_en=1.
REQ-036 Preset 23:59:58 via the set modes, then 2 ticks -> 00:00:00, with carries in the same cycle.
REQ-037 Alarm 06:00, time 05:59:59, one tick -> state=RING and buzzer=1 on that update; 60 further ticks -> RUN and buzzer=0.
REQ-038 mode_btn and inc_btn together in SET_HR -> state=SET_MIN and hour unchanged; in SET_HR, div_en=0 and ticks are ignored.
REQ-039 SNOOZE_EN build: RING, inc_btn -> SNOOZE, buzzer=0; 300 ticks -> RING; alarm_off -> RUN. Non-SNOOZE_EN build: inc_btn in RING -> no change.
REQ-040 rst=0 asserted while in RING -> next edge gives state=RUN, buzzer=0, and time 00:00:00.
